ahb_fetch_data_arbiter: RTL and testbench
=========================================

Name: ahb_fetch_data_arbiter

Overview:
- Shares the single-port instruction ROM / memory slave (64-bit HADDR/HWDATA/HRDATA interface) between the core's instruction-fetch master (I) and load/store master (D).
- Serialises requests into one address phase plus one data phase at a time and returns registered read data with a one-cycle ack pulse.
- Applies fixed D-over-I priority with a starvation limit and a HREADY wait timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is pending before I is forced.
- TIMEOUT, 16: data-phase cycles to wait for HREADY before aborting with error.

Ports:
- HCLK input 1 system clock
- HRESET input 1 asynchronous active-high reset
- i_req input 1 fetch request; held stable until i_ack
- i_addr input 64 fetch byte address
- i_ack output 1 one-cycle completion pulse, fetch port
- i_err output 1 valid with i_ack; timeout occurred
- i_rdata output 64 fetch read data, registered
- d_req input 1 data request; held stable until d_ack
- d_addr input 64 data byte address
- d_write input 1 1 = write, 0 = read
- d_size input 3 HSIZE encoding (0 = byte ... 3 = dword)
- d_wdata input 64 write data
- d_ack output 1 one-cycle completion pulse, data port
- d_err output 1 valid with d_ack; timeout occurred
- d_rdata output 64 data read data, registered
- HADDR output 64 slave address
- HWDATA output 64 slave write data
- HWRITE output 1 slave write enable
- HSIZE output 3 slave transfer size
- HTRANS output 2 slave transfer type: 2'b00 IDLE, 2'b10 NONSEQ
- HRDATA input 64 slave read data
- HREADY input 1 slave data-phase ready
- grant_d output 1 1 = current or last owner is D (debug/perf)

Behaviour:
- Reset, asynchronous and active-high, forces:
  - state IDLE, HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0
  - i_ack=d_ack=0, i_err=d_err=0, i_rdata=d_rdata=0, grant_d=0
  - starve_cnt=0, wait_cnt=0
- Reset mid-transaction discards the transaction; no ack is issued for it.
- States:
  - IDLE: on the clock edge, if any request is pending, latch the grant winner and its address/size/write/wdata, then go to ADDR. Otherwise stay in IDLE.
  - ADDR (1 cycle): HTRANS=NONSEQ; HADDR, HWRITE and HSIZE come from the latched request. I requests use HWRITE=0 and HSIZE=3'b010. Always go to DATA next.
  - DATA: HTRANS=IDLE; HWDATA holds the latched wdata (0 for I).
    - If HREADY=1: capture HRDATA into the owner's rdata, pulse the owner's ack next cycle with err=0, go to IDLE.
    - Else increment wait_cnt. When wait_cnt reaches TIMEOUT-1 with HREADY still 0: pulse ack with err=1, rdata=0, go to IDLE.
- Latency: request seen in IDLE at cycle 0, ack high at cycle 3 with zero wait states; 3+N for N wait states.
- Ack and err are high exactly one cycle. rdata holds its value until the next ack on the same port. Writes leave d_rdata unchanged.
- Priority rules:
  - Only one request pending: it wins.
  - Both pending: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
- starve_cnt:
  - increments when D wins while i_req=1
  - clears when I wins or i_req=0
  - saturates at STARVE_LIMIT
- The requester must drop req in the cycle ack is high, or keep it high to request again. The arbiter re-evaluates in the IDLE cycle following ack, so back-to-back requests are spaced 4 cycles apart.
- A request deasserted before ack (protocol violation) does not abort the in-flight transfer; its ack still fires.
- HADDR is passed through unmodified; no address range check in this block. The slave decodes its own range.
- grant_d updates at the IDLE→ADDR transition and holds until the next grant.

Decomposition:
- Shared bus package holds:
  - HTRANS_IDLE/HTRANS_NONSEQ constants
  - HSIZE_BYTE/HALF/WORD/DWORD constants
  - arbiter state encoding localparams (IDLE=2'd0, ADDR=2'd1, DATA=2'd2)
- One natural sub-module: ahb_prio_select. It is combinational plus the starve_cnt register; inputs i_req, d_req, HCLK, HRESET, grant_take; outputs sel_d.
- The state machine and data-phase capture stay in the top module.

Test Plan:
- Only i_req=1, i_addr=0x10, HRDATA=0x00000000FE51 1CE3, HREADY=1 → HADDR=0x10 with HTRANS=10 at cycle 1; i_ack=1 at cycle 3; i_rdata=0x00000000FE511CE3; i_err=0.
- Both req high from cycle 0 with STARVE_LIMIT=4, d_req kept asserted → grant order D,D,D,D,I,D; i_ack never later than the fifth completion.
- D write: d_addr=0x20, d_size=3, d_wdata=0xDEADBEEF → HWRITE=1 and HSIZE=3 in ADDR; HWDATA=0xDEADBEEF in DATA; d_ack at cycle 3; d_rdata unchanged.
- HREADY low for 2 cycles in DATA → ack at cycle 5 with correct data; held low ≥ TIMEOUT cycles → ack with err=1 and rdata=0.
- HRESET pulsed during DATA → all outputs return to reset values immediately (async); no ack afterwards. A new i_req after release completes normally.
- Back-to-back i_req held high over 3 fetches at addresses 0, 4, 8 → acks at cycles 3, 7, 11 with consecutive ROM words.

Source files
------------

// File: rtl/ahb_fetch_data_arbiter_pkg.sv
// Shared AHB-lite encodings and arbiter state for the fetch/data arbiter.
package ahb_fetch_data_arbiter_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_ADDR = ARB_ADDR,
    ST_DATA = ARB_DATA
  } arb_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic        write;
  } bus_req_t;
endpackage

// File: rtl/ahb_fetch_data_arbiter_if.sv
// Requester ports and AHB slave bus; master = arbiter view, slave = environment view.
interface ahb_fetch_data_arbiter_if;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [63:0] i_rdata;
  logic        d_req;
  logic [63:0] d_addr;
  logic        d_write;
  logic [2:0]  d_size;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [63:0] d_rdata;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        grant_d;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_write, d_size, d_wdata, HRDATA, HREADY,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           HADDR, HWDATA, HWRITE, HSIZE, HTRANS, grant_d
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_write, d_size, d_wdata, HRDATA, HREADY,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           HADDR, HWDATA, HWRITE, HSIZE, HTRANS, grant_d
  );
endinterface

// File: rtl/ahb_fetch_data_arbiter_prio.sv
// D-over-I priority select with a saturating starvation counter that forces I through.
module ahb_prio_select #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_take,
  output logic sel_d
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  assign starved = (starve_cnt_q == SW'(STARVE_LIMIT));
  assign sel_d   = d_req && (!i_req || !starved);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req)
      starve_cnt_d = '0;
    else if (grant_take) begin
      if (!sel_d)
        starve_cnt_d = '0;
      else if (!starved)
        starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
endmodule

// File: rtl/ahb_fetch_data_arbiter.sv
// Serialises fetch (I) and load/store (D) requests onto one AHB-lite slave:
// one address phase + one data phase per transfer, registered rdata and ack pulse.
module ahb_fetch_data_arbiter
  import ahb_fetch_data_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  ahb_fetch_data_arbiter_if.master bus
);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e  state_q;
  logic        sel_d, grant_take;
  bus_req_t    req_sel;
  logic [63:0] wdata_q;
  logic [WW-1:0] wait_cnt_q;

  logic        i_ack_q, i_err_q, d_ack_q, d_err_q, grant_d_q;
  logic [63:0] i_rdata_q, d_rdata_q;
  logic [63:0] haddr_q, hwdata_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [1:0]  htrans_q;

  // Requests seen during the ack cycle are stale; wait one cycle before granting.
  assign grant_take = (state_q == ST_IDLE) && (bus.i_req || bus.d_req)
                      && !(i_ack_q || d_ack_q);

  ahb_prio_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .grant_take (grant_take),
    .sel_d      (sel_d)
  );

  always_comb begin
    if (sel_d) req_sel = '{addr: bus.d_addr, wdata: bus.d_wdata, size: bus.d_size, write: bus.d_write};
    else       req_sel = '{addr: bus.i_addr, wdata: 64'd0, size: HSIZE_WORD, write: 1'b0};
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      i_ack_q    <= 1'b0;
      i_err_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      grant_d_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      htrans_q   <= HTRANS_IDLE;
    end else begin
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_take) begin
            grant_d_q <= sel_d;
            haddr_q   <= req_sel.addr;
            hsize_q   <= req_sel.size;
            hwrite_q  <= req_sel.write;
            wdata_q   <= req_sel.wdata;
            htrans_q  <= HTRANS_NONSEQ;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          htrans_q   <= HTRANS_IDLE;
          hwdata_q   <= wdata_q;
          wait_cnt_q <= '0;
          state_q    <= ST_DATA;
        end
        ST_DATA: begin
          if (bus.HREADY) begin
            if (grant_d_q) begin
              d_ack_q <= 1'b1;
              if (!hwrite_q) d_rdata_q <= bus.HRDATA;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus.HRDATA;
            end
            state_q <= ST_IDLE;
          end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
            // Abort: read data is forced to zero so a stale word is never consumed.
            if (grant_d_q) begin
              d_ack_q <= 1'b1;
              d_err_q <= 1'b1;
              if (!hwrite_q) d_rdata_q <= '0;
            end else begin
              i_ack_q   <= 1'b1;
              i_err_q   <= 1'b1;
              i_rdata_q <= '0;
            end
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.HADDR   = haddr_q;
  assign bus.HWDATA  = hwdata_q;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HSIZE   = hsize_q;
  assign bus.HTRANS  = htrans_q;
  assign bus.grant_d = grant_d_q;
endmodule

// File: tb/tb_ahb_fetch_data_arbiter.sv
// Directed bench: inputs driven and outputs sampled on the falling edge;
// the k-th falling edge after a request is driven observes cycle k.
module tb_ahb_fetch_data_arbiter;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 HCLK = ~HCLK;

  ahb_fetch_data_arbiter_if bus();

  ahb_fetch_data_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge HCLK);
  endtask

  function automatic logic [63:0] rom(input logic [63:0] a);
    return 64'hC0DE_0000_0000_0000 | a;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_htrans"}, {62'd0, bus.HTRANS}, 64'd0);
    chk({tag, "_haddr"},  bus.HADDR, 64'd0);
    chk({tag, "_hwdata"}, bus.HWDATA, 64'd0);
    chk({tag, "_ctl"},    {58'd0, bus.HWRITE, bus.HSIZE, bus.grant_d, 1'b0}, 64'd0);
    chk({tag, "_acks"},   {60'd0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 64'd0);
    chk({tag, "_irdata"}, bus.i_rdata, 64'd0);
    chk({tag, "_drdata"}, bus.d_rdata, 64'd0);
  endtask

  initial begin
    int cyc, n, c5, acks;
    logic [5:0] ord;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0;
    bus.d_write = 0; bus.d_size = 0; bus.d_wdata = 0; bus.HRDATA = 0; bus.HREADY = 1;

    // Reset state
    nxt(); nxt();
    chk_reset_outs("rst");
    HRESET = 0;
    nxt();

    // Single fetch, zero wait states
    bus.i_req = 1; bus.i_addr = 64'h10; bus.HRDATA = 64'h0000_0000_FE51_1CE3;
    nxt();
    chk("f1_haddr", bus.HADDR, 64'h10);
    chk("f1_htrans", {62'd0, bus.HTRANS}, 64'd2);
    chk("f1_hsize_hwrite", {60'd0, bus.HSIZE, bus.HWRITE}, {60'd0, 3'b010, 1'b0});
    chk("f1_grant_d", {63'd0, bus.grant_d}, 64'd0);
    nxt();
    chk("f1_data_htrans", {62'd0, bus.HTRANS}, 64'd0);
    chk("f1_noack_c2", {63'd0, bus.i_ack}, 64'd0);
    nxt();
    chk("f1_ack_c3", {62'd0, bus.i_ack, bus.i_err}, 64'd2);
    chk("f1_rdata", bus.i_rdata, 64'h0000_0000_FE51_1CE3);
    bus.i_req = 0;
    nxt();
    chk("f1_ack_pulse", {63'd0, bus.i_ack}, 64'd0);
    chk("f1_rdata_hold", bus.i_rdata, 64'h0000_0000_FE51_1CE3);

    // D read then D write: write must leave d_rdata untouched
    bus.d_req = 1; bus.d_addr = 64'h30; bus.d_write = 0; bus.d_size = 3'd3;
    bus.HRDATA = 64'hA5A5_5A5A_0123_4567;
    nxt(); nxt(); nxt();
    chk("dr_ack_c3", {62'd0, bus.d_ack, bus.d_err}, 64'd2);
    chk("dr_rdata", bus.d_rdata, 64'hA5A5_5A5A_0123_4567);
    chk("dr_i_quiet", {63'd0, bus.i_ack}, 64'd0);
    bus.d_req = 0;
    nxt();
    bus.d_req = 1; bus.d_addr = 64'h20; bus.d_write = 1; bus.d_size = 3'd3;
    bus.d_wdata = 64'h0000_0000_DEAD_BEEF; bus.HRDATA = 64'h1234;
    nxt();
    chk("dw_addr", bus.HADDR, 64'h20);
    chk("dw_ctl", {59'd0, bus.HTRANS, bus.HSIZE}, {59'd0, 2'b10, 3'd3});
    chk("dw_hwrite_grant", {62'd0, bus.HWRITE, bus.grant_d}, 64'd3);
    nxt();
    chk("dw_hwdata", bus.HWDATA, 64'h0000_0000_DEAD_BEEF);
    nxt();
    chk("dw_ack_c3", {62'd0, bus.d_ack, bus.d_err}, 64'd2);
    chk("dw_rdata_kept", bus.d_rdata, 64'hA5A5_5A5A_0123_4567);
    bus.d_req = 0; bus.d_write = 0;
    nxt();

    // Two wait states: ack moves from cycle 3 to cycle 5
    bus.i_req = 1; bus.i_addr = 64'h40; bus.HREADY = 0; bus.HRDATA = 64'h1111_2222_3333_4444;
    nxt(); nxt();
    nxt();
    chk("ws_noack_c3", {63'd0, bus.i_ack}, 64'd0);
    nxt();
    chk("ws_noack_c4", {63'd0, bus.i_ack}, 64'd0);
    bus.HREADY = 1;
    nxt();
    chk("ws_ack_c5", {62'd0, bus.i_ack, bus.i_err}, 64'd2);
    chk("ws_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
    bus.i_req = 0;
    nxt();

    // Async reset during the data phase drops the transfer
    bus.i_req = 1; bus.i_addr = 64'h60; bus.HREADY = 0;
    nxt(); nxt();
    chk("rm_in_data", {62'd0, bus.HTRANS}, 64'd0);
    #1 HRESET = 1;
    #1 chk_reset_outs("rm");
    bus.i_req = 0;
    nxt();
    HRESET = 0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      nxt();
      if (bus.i_ack || bus.d_ack) acks++;
    end
    chk("rm_no_ack", 64'(acks), 64'd0);
    bus.i_req = 1; bus.i_addr = 64'h70; bus.HREADY = 1; bus.HRDATA = 64'h7777;
    nxt(); nxt(); nxt();
    chk("rm_after_ack", {62'd0, bus.i_ack, bus.i_err}, 64'd2);
    chk("rm_after_rdata", bus.i_rdata, 64'h7777);
    bus.i_req = 0;
    nxt();

    // HREADY stuck low: timeout abort with err and zero data
    bus.i_req = 1; bus.i_addr = 64'h50; bus.HREADY = 0; bus.HRDATA = 64'hBAD;
    cyc = 0;
    while (!bus.i_ack && cyc < 40) begin
      nxt();
      cyc++;
    end
    chk("to_ack_seen", {63'd0, bus.i_ack}, 64'd1);
    chk("to_err", {63'd0, bus.i_err}, 64'd1);
    chk("to_rdata_zero", bus.i_rdata, 64'd0);
    chk("to_cycle_window", {63'd0, (cyc >= 17 && cyc <= 18)}, 64'd1);
    bus.i_req = 0; bus.HREADY = 1;
    nxt();
    chk("to_err_pulse", {63'd0, bus.i_err}, 64'd0);

    // Both pending: D,D,D,D then starved I, then D again
    bus.i_req = 1; bus.i_addr = 64'h80; bus.d_req = 1; bus.d_addr = 64'h90; bus.d_write = 0;
    bus.HRDATA = 64'h5555;
    n = 0; cyc = 0; c5 = 0; ord = '0;
    while (n < 6 && cyc < 60) begin
      nxt();
      cyc++;
      if (bus.i_ack || bus.d_ack) begin
        ord[n] = bus.d_ack;
        if (n == 4) c5 = cyc;
        n++;
      end
    end
    bus.i_req = 0; bus.d_req = 0;
    chk("st_count", 64'(n), 64'd6);
    chk("st_order", {58'd0, ord}, {58'd0, 6'b101111});
    chk("st_fifth_cycle", 64'(c5), 64'd19);
    nxt();

    // Back-to-back fetches with i_req held: acks at 3, 7, 11
    bus.i_req = 1; bus.i_addr = 64'h0; bus.HRDATA = rom(64'h0);
    for (int c = 1; c <= 11; c++) begin
      nxt();
      chk($sformatf("bb_ack_c%0d", c), {63'd0, bus.i_ack}, {63'd0, (c == 3 || c == 7 || c == 11)});
      if (c == 3 || c == 7 || c == 11) begin
        chk($sformatf("bb_rdata_c%0d", c), bus.i_rdata, rom(64'((c - 3) / 4 * 4)));
        bus.i_addr = bus.i_addr + 64'd4;
        bus.HRDATA = rom(bus.i_addr);
      end
    end
    bus.i_req = 0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
